putch_buf: RTL
==============

# putch_buf

Console output buffer between the core's `putch` special instruction (opcode 7, character in `a0[7:0]`) and the simulation UART output port. It accepts one character per cycle from the execute path, holds it in a small FIFO, and drains it to `uart_out_valid`/`uart_out_ch` at a rate the console model can absorb. Characters that arrive while the FIFO is full are dropped and counted, so the core never stalls on console output.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two and at least 2.
- `GAP`, default 4: cycles from one `uart_out_valid` pulse to the next; must be at least 1, and 1 means back-to-back output.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `wen` in 1: putch request, one character per cycle while high.
- `wdata` in 8: character to print, sampled when `wen` is high.
- `uart_out_valid` out 1: single-cycle strobe; `uart_out_ch` is valid in this cycle.
- `uart_out_ch` out 8: output character.
- `full` out 1: FIFO holds `DEPTH` entries.
- `empty` out 1: FIFO holds 0 entries and no character is being emitted.
- `drop_cnt` out 16: number of dropped characters; saturates at 0xFFFF.

## Operation
- **Storage:** circular buffer `mem[DEPTH]`.
  - Pointers `wptr` and `rptr` are log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - `count = wptr - rptr`, modulo 2^(log2(DEPTH)+1).
- **Push:** happens when `wen` is high and (`count < DEPTH` or a pop occurs in the same cycle).
- **Drop:** when `wen` is high while the FIFO is full and no pop occurs, the character is discarded and `drop_cnt` increments, saturating at 0xFFFF.
- **Drain FSM states:** IDLE, EMIT, WAIT.
  - IDLE: if `count != 0`, pop `mem[rptr]` into the `uart_out_ch` register, set `uart_out_valid`, and go to EMIT. Otherwise stay in IDLE.
  - EMIT (one cycle, valid is high): clear valid. If `GAP == 1` and `count != 0`, pop the next entry immediately and stay in EMIT. Otherwise go to WAIT with `gap_cnt = GAP - 2`, or go straight to IDLE when `GAP <= 2`.
  - WAIT: decrement `gap_cnt`; go to IDLE when it reaches 0.
- **Spacing:** successive valid strobes are exactly `GAP` cycles apart while the FIFO stays non-empty.
- **Simultaneous events:**
  - Push and pop in the same cycle when full: both succeed and `count` is unchanged.
  - Push into an empty FIFO: the data is not bypassed; it is popped at the next edge, at the earliest.
- **Status outputs:** `full` and `empty` are combinational from the pointers and state; `empty` also requires state IDLE.
- **Reset values (asynchronous, at any time):**
  - State IDLE; `wptr`, `rptr`, `gap_cnt` all 0.
  - `uart_out_valid` 0, `uart_out_ch` 0x00, `drop_cnt` 0.
  - `full` 0, `empty` 1.
  - FIFO contents are not reset.
  - A character in flight or queued at reset is lost, and it does not count as a drop.

## Timing
- **Latency:** `wen` at edge N into an idle, empty buffer gives `uart_out_valid` high in the cycle after edge N+1, for exactly one cycle.
- **Throughput:** one character per `GAP` cycles.
- **Input handshake:** `wen` has no ready signal; the producer never waits.
- **Registered outputs:** `uart_out_valid`, `uart_out_ch`, and `drop_cnt` are driven from flops.
- **Reset release:** sampling starts at the first rising edge after `rst` deasserts.

## Structure
- A shared package holds the state encoding (`PB_IDLE`, `PB_EMIT`, `PB_WAIT`), the `putch` opcode constant 7, and the `drop_cnt` width 16.
- One natural sub-module, `sync_fifo`, implements the storage, pointers, `full`/`empty`, and the push-with-simultaneous-pop rule. `putch_buf` contains the drain FSM, the gap counter, and the drop counter.

## Test plan
- **Single character:** after reset, `wen=1`, `wdata=0x41` for one cycle → `uart_out_valid` is a one-cycle pulse with `uart_out_ch=0x41` two edges later; `empty` returns to 1.
- **Burst with GAP=4:** 5 consecutive writes of "HELLO" → 5 valid pulses exactly 4 cycles apart, in order; `drop_cnt=0`.
- **Overflow, DEPTH=16, GAP=4:** write 0x00–0x1F on 32 consecutive cycles → the first 16 plus those pushed as pops free slots are emitted in order; `drop_cnt` equals 32 minus emitted-plus-queued; `full` toggles correctly.
- **Full with simultaneous push/pop:** fill the FIFO, then write while a pop occurs → the write is accepted, `count` stays at 16, and `drop_cnt` is unchanged.
- **GAP=1:** 3 back-to-back writes → valid is high for 3 consecutive cycles with the characters in order.
- **Reset mid-operation:** assert `rst` low asynchronously while in WAIT with 5 entries queued → outputs go immediately to their reset values; after release, a new write of 0x5A emits only 0x5A.

Source files
------------

// File: rtl/putch_buf_pkg.sv
// Shared constants for the putch console buffer: drain FSM encoding, opcode and counter width.
package putch_buf_pkg;

  localparam logic [1:0] PB_IDLE = 2'd0;
  localparam logic [1:0] PB_EMIT = 2'd1;
  localparam logic [1:0] PB_WAIT = 2'd2;

  localparam logic [6:0] PUTCH_OPCODE = 7'd7;

  localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/putch_buf_sync_fifo.sv
// Circular-buffer FIFO with extra pointer MSB; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      count;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign count   = wptr_q - rptr_q;
  assign full_o  = (count == (AW + 1)'(DEPTH));
  assign empty_o = (count == '0);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;

  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/putch_buf.sv
// Console output buffer: queues putch characters and drains them as UART strobes spaced GAP cycles.
module putch_buf
  import putch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned GAP   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wen_i,
  input  logic [7:0]            wdata_i,
  output logic                  uart_out_valid_o,
  output logic [7:0]            uart_out_ch_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned GapW = (GAP > 2) ? $clog2(GAP) : 1;

  logic [1:0]            state_q, state_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic                  valid_q, valid_d;
  logic [7:0]            ch_q, ch_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic       pop;
  logic       fifo_empty, fifo_drop;
  logic [7:0] fifo_rdata;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wen_i),
    .pop_i   (pop),
    .wdata_i (wdata_i),
    .rdata_o (fifo_rdata),
    .full_o  (full_o),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // Back-to-back pops from EMIT only when strobes are meant to be adjacent.
  assign pop = !fifo_empty && ((state_q == PB_IDLE) || ((GAP == 1) && (state_q == PB_EMIT)));

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    case (state_q)
      PB_IDLE: begin
        if (pop) begin
          ch_d    = fifo_rdata;
          valid_d = 1'b1;
          state_d = PB_EMIT;
        end
      end
      PB_EMIT: begin
        if (pop) begin
          ch_d    = fifo_rdata;
          valid_d = 1'b1;
        end else if (GAP > 2) begin
          gap_d   = GapW'(GAP - 2);
          state_d = PB_WAIT;
        end else begin
          state_d = PB_IDLE;
        end
      end
      PB_WAIT: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GapW'(1)) state_d = PB_IDLE;
      end
      default: state_d = PB_IDLE;
    endcase
  end

  assign drop_d = (fifo_drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PB_IDLE;
      gap_q   <= '0;
      valid_q <= 1'b0;
      ch_q    <= 8'h00;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      drop_q  <= drop_d;
    end
  end

  assign uart_out_valid_o = valid_q;
  assign uart_out_ch_o    = ch_q;
  assign drop_cnt_o       = drop_q;
  assign empty_o          = fifo_empty && (state_q == PB_IDLE);

endmodule
